// File: rtl/lc3_intc_pkg.sv
// LC-3 interrupt controller shared types and constants.
// Edge/level detection selected by LC3_INTC_EDGE_EN.
package lc3_intc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_REQ  = 2'd2
   } state_t;

   localparam logic [4:0] ADDR_MASK     = 5'd0;
   localparam logic [4:0] ADDR_PEND     = 5'd1;
   localparam logic [4:0] ADDR_STATUS   = 5'd2;
   localparam logic [4:0] ADDR_PRI_BASE = 5'd16;

   localparam int PRI_W = 3;

endpackage

// File: rtl/lc3_intc_prio_sel.sv
// Combinational winner select: highest priority, lowest index on ties.
// Part of lc3_intc (LC3_INTC_EDGE_EN has no effect here).
module lc3_intc_prio_sel
   import lc3_intc_pkg::*;
#(
   parameter int NCH = 8
) (
   input  logic [NCH-1:0]            i_elig,
   input  logic [NCH-1:0][PRI_W-1:0] i_pri,
   output logic [3:0]                o_idx,
   output logic [PRI_W-1:0]          o_pri,
   output logic                      o_valid
);

   logic             w_v;
   logic [3:0]       w_idx;
   logic [PRI_W-1:0] w_pri;

   always_comb begin
      w_v   = 1'b0;
      w_idx = '0;
      w_pri = '0;
      // strict compare keeps the lower index on a tie
      for (int i = 0; i < NCH; i++) begin
         if (i_elig[i] && (!w_v || (i_pri[i] > w_pri))) begin
            w_v   = 1'b1;
            w_idx = 4'(i);
            w_pri = i_pri[i];
         end
      end
   end

   assign o_idx   = w_idx;
   assign o_pri   = w_pri;
   assign o_valid = w_v;

endmodule

// File: rtl/lc3_intc.sv
// LC-3 prioritised interrupt controller with MMIO registers.
// Define LC3_INTC_EDGE_EN for rising-edge capture; default is level.
module lc3_intc
   import lc3_intc_pkg::*;
#(
   parameter int         NCH      = 8,
   parameter logic [7:0] VEC_BASE = 8'h80
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   irq_src,
   input  logic [4:0]       reg_addr,
   input  logic             reg_we,
   input  logic [15:0]      reg_wdata,
   output logic [15:0]      reg_rdata,
   input  logic [2:0]       cpu_pri,
   input  logic             int_ack,
   output logic             IRQ,
   output logic [7:0]       INTV,
   output logic [2:0]       INTP
);

   logic [NCH-1:0]            r_s1;
   logic [NCH-1:0]            r_s2;
   logic [NCH-1:0]            r_mask;
   logic [NCH-1:0]            r_pend;
   logic [NCH-1:0][PRI_W-1:0] r_pri;
   state_t                    r_state;
   state_t                    w_next;
   logic [3:0]                r_win;
   logic [PRI_W-1:0]          r_wpri;

   logic [NCH-1:0]   w_evt;
   logic [NCH-1:0]   w_elig;
   logic [NCH-1:0]   w_win_oh;
   logic [NCH-1:0]   w_ack_clr;
   logic [NCH-1:0]   w_w1c;
   logic             w_win_elig;
   logic [3:0]       w_sel_idx;
   logic [PRI_W-1:0] w_sel_pri;
   logic             w_sel_valid;
   logic [15:0]      w_rd;
   logic             w_unused;

   assign w_unused = ^reg_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= irq_src;
         r_s2 <= r_s1;
      end
   end

`ifdef LC3_INTC_EDGE_EN
   logic [NCH-1:0] r_s3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_s3 <= '0;
      else      r_s3 <= r_s2;
   end

   assign w_evt = r_s2 & ~r_s3;
`else
   assign w_evt = r_s2;
`endif

   always_comb begin
      w_elig   = '0;
      w_win_oh = '0;
      for (int i = 0; i < NCH; i++) begin
         w_elig[i]   = r_pend[i] & r_mask[i] & (r_pri[i] > cpu_pri);
         w_win_oh[i] = (r_win == 4'(i));
      end
   end

   assign w_win_elig = |(w_elig & w_win_oh);
   assign w_ack_clr  = w_win_oh & {NCH{int_ack && (r_state == ST_REQ)}};
   assign w_w1c      = (reg_we && (reg_addr == ADDR_PEND)) ?
                       reg_wdata[NCH-1:0] : '0;

   lc3_intc_prio_sel #(
      .NCH     (NCH)
   ) u_sel (
      .i_elig  (w_elig),
      .i_pri   (r_pri),
      .o_idx   (w_sel_idx),
      .o_pri   (w_sel_pri),
      .o_valid (w_sel_valid)
   );

   // a fresh event outranks any clear landing on the same edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_pend <= '0;
      else      r_pend <= (r_pend & ~(w_w1c | w_ack_clr)) | w_evt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mask <= '0;
         r_pri  <= '0;
      end else if (reg_we) begin
         if (reg_addr == ADDR_MASK) r_mask <= reg_wdata[NCH-1:0];
         for (int i = 0; i < NCH; i++) begin
            if (reg_addr == (ADDR_PRI_BASE + 5'(i)))
               r_pri[i] <= reg_wdata[PRI_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_win   <= '0;
         r_wpri  <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == ST_ARB) && w_sel_valid) begin
            r_win  <= w_sel_idx;
            r_wpri <= w_sel_pri;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (|w_elig) w_next = ST_ARB;
         ST_ARB:  w_next = w_sel_valid ? ST_REQ : ST_IDLE;
         ST_REQ: begin
            if (int_ack)
               w_next = ST_IDLE;
            else if (!w_win_elig ||
                     (w_sel_valid && (w_sel_pri > r_wpri)))
               w_next = ST_ARB;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign IRQ  = (r_state == ST_REQ);
   assign INTV = IRQ ? (VEC_BASE + {4'b0, r_win}) : 8'h00;
   assign INTP = IRQ ? r_wpri : 3'd0;

   always_comb begin
      w_rd = '0;
      if (reg_addr == ADDR_MASK) begin
         w_rd[NCH-1:0] = r_mask;
      end else if (reg_addr == ADDR_PEND) begin
         w_rd[NCH-1:0] = r_pend;
      end else if (reg_addr == ADDR_STATUS) begin
         w_rd[15]    = IRQ;
         w_rd[14:12] = INTP;
         w_rd[3:0]   = IRQ ? r_win : 4'd0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (reg_addr == (ADDR_PRI_BASE + 5'(i)))
               w_rd[PRI_W-1:0] = r_pri[i];
         end
      end
   end

   assign reg_rdata = w_rd;

endmodule

// File: tb/tb_lc3_intc.sv
// Directed bench for lc3_intc: register table plus arbitration sequences.
// Honours LC3_INTC_EDGE_EN for the event-versus-ack case.
module tb_lc3_intc;
   import lc3_intc_pkg::*;

   localparam int NCH = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [NCH-1:0] irq_src = '0;
   logic [4:0]     reg_addr = ADDR_PEND;
   logic           reg_we = 1'b0;
   logic [15:0]    reg_wdata = '0;
   logic [15:0]    reg_rdata;
   logic [2:0]     cpu_pri = '0;
   logic           int_ack = 1'b0;
   logic           IRQ;
   logic [7:0]     INTV;
   logic [2:0]     INTP;

   int total = 0;
   int bad   = 0;

   lc3_intc #(.NCH(NCH), .VEC_BASE(8'h80)) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_src   (irq_src),
      .reg_addr  (reg_addr),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .cpu_pri   (cpu_pri),
      .int_ack   (int_ack),
      .IRQ       (IRQ),
      .INTV      (INTV),
      .INTP      (INTP)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [4:0]  waddr;
      logic [15:0] wdata;
      logic [4:0]  raddr;
      logic [15:0] exp;
   } vec_t;

   vec_t tv[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [15:0] d);
      reg_addr  = a;
      reg_wdata = d;
      reg_we    = 1'b1;
      step();
      reg_we    = 1'b0;
      reg_wdata = '0;
      reg_addr  = ADDR_PEND;
   endtask

   task automatic rd(input logic [4:0] a, output logic [15:0] d);
      reg_addr = a;
      #1;
      d = reg_rdata;
   endtask

   task automatic pulse(input int ch);
      irq_src[ch] = 1'b1;
      step();
      irq_src[ch] = 1'b0;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
   endtask

   task automatic wait_vec(input string nm, input logic [7:0] v);
      int n = 0;
      while (!(IRQ && (INTV == v)) && (n < 30)) begin
         step();
         n++;
      end
      chk({nm, "_irq"}, {15'd0, IRQ}, 16'd1);
      chk({nm, "_intv"}, {8'd0, INTV}, {8'd0, v});
   endtask

   initial begin
      logic [15:0] d;
      int          n;

      tv[0] = '{"mask_all",  ADDR_MASK,        16'hFFFF, ADDR_MASK,   16'h00FF};
      tv[1] = '{"pri0",      ADDR_PRI_BASE,    16'h0004, ADDR_PRI_BASE, 16'h0004};
      tv[2] = '{"pri7_wide", 5'd23,            16'hFFFF, 5'd23,       16'h0007};
      tv[3] = '{"pri8_none", 5'd24,            16'h0005, 5'd24,       16'h0000};
      tv[4] = '{"unused3",   5'd3,             16'hFFFF, 5'd3,        16'h0000};
      tv[5] = '{"status_ro", ADDR_STATUS,      16'hFFFF, ADDR_STATUS, 16'h0000};
      tv[6] = '{"pend_w1c0", ADDR_PEND,        16'hFFFF, ADDR_PEND,   16'h0000};
      tv[7] = '{"mask_zero", ADDR_MASK,        16'h0000, ADDR_MASK,   16'h0000};

      #1;
      chk("rst_irq",  {15'd0, IRQ}, 16'd0);
      chk("rst_intv", {8'd0, INTV}, 16'd0);
      chk("rst_intp", {13'd0, INTP}, 16'd0);
      rd(ADDR_MASK, d);     chk("rst_mask", d, 16'd0);
      rd(ADDR_PEND, d);     chk("rst_pend", d, 16'd0);
      rd(ADDR_PRI_BASE, d); chk("rst_pri0", d, 16'd0);
      step();
      step();
      rst = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         wr(tv[i].waddr, tv[i].wdata);
         rd(tv[i].raddr, d);
         chk(tv[i].nm, d, tv[i].exp);
      end
      wr(5'd23, 16'd0);

      // single channel, latency and ack
      wr(ADDR_PRI_BASE, 16'd4);
      wr(ADDR_MASK, 16'h0001);
      cpu_pri = 3'd2;
      pulse(0);
      n = 0;
      rd(ADDR_PEND, d);
      while (!d[0] && (n < 20)) begin
         step();
         rd(ADDR_PEND, d);
         n++;
      end
      chk("lat_pend", {15'd0, d[0]}, 16'd1);
      chk("lat_t0", {15'd0, IRQ}, 16'd0);
      step();
      chk("lat_t1", {15'd0, IRQ}, 16'd0);
      step();
      chk("lat_t2", {15'd0, IRQ}, 16'd1);
      chk("c0_intv", {8'd0, INTV}, 16'h0080);
      chk("c0_intp", {13'd0, INTP}, 16'd4);
      rd(ADDR_STATUS, d);
      chk("c0_status", d, 16'hC000);
      ack();
      chk("ack_irq", {15'd0, IRQ}, 16'd0);
      rd(ADDR_PEND, d);
      chk("ack_pend", d, 16'd0);

      // tie on priority: lowest index first
      wr(5'd19, 16'd6);
      wr(5'd21, 16'd6);
      wr(ADDR_MASK, 16'h0028);
      irq_src = 8'h28;
      step();
      irq_src = '0;
      wait_vec("tie_first", 8'h83);
      chk("tie_intp", {13'd0, INTP}, 16'd6);
      ack();
      wait_vec("tie_second", 8'h85);
      ack();
      wr(ADDR_MASK, 16'h0000);

      // cpu priority masks and unmasks the request
      wr(5'd17, 16'd2);
      wr(ADDR_MASK, 16'h0002);
      cpu_pri = 3'd1;
      pulse(1);
      wait_vec("cp_first", 8'h81);
      cpu_pri = 3'd3;
      step();
      chk("cp_drop", {15'd0, IRQ}, 16'd0);
      step();
      cpu_pri = 3'd1;
      step();
      chk("cp_arb", {15'd0, IRQ}, 16'd0);
      step();
      chk("cp_again", {15'd0, IRQ}, 16'd1);
      chk("cp_intv", {8'd0, INTV}, 16'h0081);
      ack();
      wr(ADDR_MASK, 16'h0000);

      // pre-emption by a higher-priority channel
      wr(5'd18, 16'd7);
      wr(ADDR_MASK, 16'h0005);
      cpu_pri = 3'd0;
      pulse(0);
      wait_vec("pre_low", 8'h80);
      chk("pre_low_p", {13'd0, INTP}, 16'd4);
      pulse(2);
      wait_vec("pre_high", 8'h82);
      chk("pre_high_p", {13'd0, INTP}, 16'd7);
      ack();
      wait_vec("pre_resume", 8'h80);
      ack();
      wr(ADDR_MASK, 16'h0000);

      // new event coincident with ack
      wr(ADDR_MASK, 16'h0001);
`ifdef LC3_INTC_EDGE_EN
      pulse(0);
      wait_vec("ev_req", 8'h80);
      irq_src[0] = 1'b1;
      step();
      step();
      ack();
      chk("ev_irq", {15'd0, IRQ}, 16'd0);
      rd(ADDR_PEND, d);
      chk("ev_pend", d, 16'h0001);
`else
      irq_src[0] = 1'b1;
      wait_vec("ev_req", 8'h80);
      ack();
      chk("ev_irq", {15'd0, IRQ}, 16'd0);
      step();
      rd(ADDR_PEND, d);
      chk("ev_pend", d, 16'h0001);
`endif

      // asynchronous reset while requesting
      wait_vec("ar_req", 8'h80);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_irq",  {15'd0, IRQ}, 16'd0);
      chk("ar_intv", {8'd0, INTV}, 16'd0);
      chk("ar_intp", {13'd0, INTP}, 16'd0);
      rd(ADDR_MASK, d);     chk("ar_mask", d, 16'd0);
      rd(ADDR_PEND, d);     chk("ar_pend", d, 16'd0);
      rd(5'd18, d);         chk("ar_pri2", d, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lc3_intc.md
LC3_INTC -- requirements
Module: lc3_intc

Interface
REQ-001 SHALL have parameter NCH, default 8, giving the number of interrupt channels (legal range 1..16).
REQ-002 SHALL have parameter VEC_BASE, default 8'h80, giving the vector for channel 0.
REQ-003 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port irq_src  in  NCH  interrupt request lines from peripherals.
REQ-006 SHALL have port reg_addr  in  5  MMIO register address.
REQ-007 SHALL have port reg_we  in  1  MMIO write strobe, one cycle per write.
REQ-008 SHALL have port reg_wdata  in  16  MMIO write data.
REQ-009 SHALL have port reg_rdata  out  16  MMIO read data, combinational from reg_addr.
REQ-010 SHALL have port cpu_pri  in  3  current core PSR priority.
REQ-011 SHALL have port int_ack  in  1  single-cycle pulse from the core when it takes the interrupt.
REQ-012 SHALL have port IRQ  out  1  interrupt request to the core.
REQ-013 SHALL have port INTV  out  8  interrupt vector.
REQ-014 SHALL have port INTP  out  3  interrupt priority.

Function
REQ-015 SHALL provide these registers:
- addr 0 MASK: R/W, bit i enables channel i.
- addr 1 PEND: read returns pending bits; write-1-to-clear.
- addr 2 STATUS: read-only; [15] IRQ, [14:12] INTP, [3:0] winner index.
- addr 16+i PRI[i]: R/W, 3-bit channel priority.
- Unused addresses and bits read 0; writes to them are ignored.
REQ-016 PEND[i] SHALL set on the cycle following a qualifying event on irq_src[i]; the qualifying event is defined by REQ-030.
REQ-017 Eligible channel SHALL mean PEND[i] & MASK[i] & (PRI[i] > cpu_pri).
REQ-018 The winner SHALL be the eligible channel with the highest PRI; on a priority tie, the lowest index wins.
REQ-019 The FSM SHALL have three states: IDLE, ARB and REQ.
- IDLE -> ARB when any channel is eligible.
- ARB registers the winner index and its priority, then goes to REQ.
- REQ asserts IRQ, INTV = VEC_BASE + winner and INTP = PRI[winner]; these values are held stable for as long as the FSM stays in REQ.
REQ-020 In REQ, int_ack SHALL clear PEND[winner] and move the FSM to IDLE; IRQ SHALL be 0 on the next cycle.
REQ-021 In REQ without int_ack, if the winner becomes ineligible (masked, cleared, or cpu_pri >= INTP), IRQ SHALL deassert next cycle and the FSM SHALL go to ARB.
REQ-022 A newly eligible channel with strictly higher priority than the current winner SHALL cause REQ -> ARB (pre-emption re-arbitration).
REQ-023 Latency SHALL be 2 cycles from PEND set to IRQ high: pending at edge t, ARB at t+1, IRQ at t+2.
REQ-024 int_ack outside REQ SHALL be ignored.
REQ-025 When int_ack and a PEND write-1-to-clear hit the same bit in the same cycle, the bit SHALL clear.
REQ-026 When a new qualifying event and int_ack (or a write-1-to-clear) hit the same channel in the same cycle, the new event SHALL win and PEND stays 1.
REQ-027 When IRQ=0, INTV and INTP SHALL be 0.

Reset
REQ-028 Asserting rst (low) SHALL immediately force:
- FSM to IDLE.
- IRQ=0, INTV=0, INTP=0.
- MASK=0, PEND=0, all PRI=0.
- Edge-detect history registers to 0.
REQ-029 Reset asserted mid-REQ SHALL drop IRQ asynchronously; no int_ack is expected afterwards.

Configuration
REQ-030 Macro LC3_INTC_EDGE_EN SHALL select how irq_src events are detected.
- Defined: irq_src is synchronised with 2 flops, and a rising edge sets PEND; PEND then holds until acknowledged or cleared.
- Undefined: a synchronised level sets PEND every cycle it is high, so ack or clear of a still-high line re-pends it the following cycle.

Structure
REQ-031 Package lc3_intc_pkg SHALL hold:
- the FSM state enum;
- register address constants (MASK, PEND, STATUS, PRI_BASE);
- the priority width constant (3).
REQ-032 The winner selection SHALL be a combinational sub-module lc3_intc_prio_sel (inputs: eligible vector, PRI array; outputs: index, priority, valid).

Verification
REQ-033 MASK=0x0001, PRI[0]=4, cpu_pri=2, pulse irq_src[0] -> IRQ=1 two cycles after PEND sets, INTV=8'h80, INTP=4; int_ack -> IRQ=0 next cycle, PEND=0.
REQ-034 Channels 3 and 5 both PRI=6, both pending and enabled -> INTV=8'h83; after ack -> INTV=8'h85.
REQ-035 During REQ for channel 1 (PRI=2), raise cpu_pri to 3 -> IRQ=0 next cycle; return cpu_pri to 1 -> IRQ reasserts 2 cycles later.
REQ-036 Channel 2 (PRI=7) pends while channel 0 (PRI=4) is in REQ -> re-arbitration, INTV=8'h82, INTP=7.
REQ-037 Edge build: new rising edge on channel 0 in the same cycle as int_ack -> PEND[0] stays 1. Level build: hold irq_src[0] high through ack -> PEND[0] reads 1 one cycle later.
REQ-038 Assert rst low during REQ -> IRQ, INTV, INTP and all registers read 0 immediately, without waiting for a clock edge.
